// File: rtl/l2_ingress_port_pkg.sv
// Shared definitions for the L2 ingress port.
// Holds the start-of-frame delimiter, frame field positions, the broadcast
// address, the line-idle history pattern and the deserializer state type.
package l2_ingress_port_pkg;

    // Start-of-frame delimiter, occupying the top nibble of every frame
    localparam int unsigned SFD_W  = 4;
    localparam logic [SFD_W-1:0] SFD = 4'b0101;

    // Frame layout: {SFD[15:12], Dest[11:8], Src[7:4], Payload[3:0]}
    localparam int unsigned SFD_LO  = 12;
    localparam int unsigned DEST_LO = 8;
    localparam int unsigned SRC_LO  = 4;
    localparam int unsigned PAY_LO  = 0;

    // All-ones address is broadcast and is never learned as a source
    localparam logic [3:0] BCAST_ADDR = 4'hF;

    // Line history after reset or after a completed frame (idle line is high)
    localparam logic [SFD_W-1:0] HIST_IDLE = 4'b1111;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/l2_ingress_port_frame_fifo.sv
// frame_fifo: synchronous frame buffer between the deserializer and the fabric.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and frame; accepted when not full, or when
//                    full and a pop happens on the same edge
//   pop              read request; ignored when empty
//   pop_data         head-of-FIFO frame, forced to zero while empty
//   full, empty      occupancy flags
module frame_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    assign do_pop  = pop && !empty;
    // A write into a full buffer is still taken when the head leaves on the
    // same edge; the slot being written is the one being vacated.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l2_ingress_port.sv
// l2_ingress_port: serial-to-parallel ingress for one switch port.
// Hunts for the SFD on the serial line, captures the remaining frame bits,
// buffers whole frames in frame_fifo and reports learnable source addresses.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rx_bit           serial line, idle high, MSB first, one bit per clk
//   frame_out        head-of-FIFO frame towards the fabric (0 when empty)
//   frame_out_valid  FIFO non-empty
//   frame_out_ready  fabric accepts frame_out on this edge
//   learn_valid      one-cycle pulse after a buffered frame with non-broadcast Src
//   learn_src        Src field of that frame
//   drop_count       saturating count of frames lost to overflow
module l2_ingress_port
    import l2_ingress_port_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_bit,
    output logic [DEPTH-1:0]      frame_out,
    output logic                  frame_out_valid,
    input  logic                  frame_out_ready,
    output logic                  learn_valid,
    output logic [ADDR_WIDTH-1:0] learn_src,
    output logic [7:0]            drop_count
);

    localparam int unsigned CAP_BITS = DEPTH - SFD_W;
    localparam int unsigned CNT_W    = $clog2(CAP_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAP_BITS - 1);

    rx_state_t state, state_nxt;

    // Only the three most recent line bits can complete an SFD match together
    // with the incoming bit, so the oldest history bit is never stored.
    logic [SFD_W-2:0]    hist, hist_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    // Holds all captured bits except the last, which is taken straight from
    // the line on the write edge.
    logic [CAP_BITS-2:0] cap, cap_nxt;

    logic                  push;
    logic [DEPTH-1:0]      push_frame;
    logic [ADDR_WIDTH-1:0] push_src;
    logic                  push_bcast;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    // ---------------- deserializer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            hist  <= HIST_IDLE[SFD_W-2:0];
            cnt   <= '0;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            hist  <= hist_nxt;
            cnt   <= cnt_nxt;
            cap   <= cap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        cnt_nxt   = cnt;
        cap_nxt   = cap;
        push      = 1'b0;
        case (state)
            HUNT: begin
                hist_nxt = {hist[SFD_W-3:0], rx_bit};
                if ({hist, rx_bit} == SFD) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                end
            end
            CAPTURE: begin
                cap_nxt = {cap[CAP_BITS-3:0], rx_bit};
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    push      = 1'b1;
                    state_nxt = HUNT;
                    hist_nxt  = HIST_IDLE[SFD_W-2:0];
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    assign push_frame = {SFD, cap, rx_bit};
    assign push_src   = push_frame[SRC_LO +: ADDR_WIDTH];
    assign push_bcast = (push_src == BCAST_ADDR[ADDR_WIDTH-1:0]);

    // ---------------- frame buffer ----------------
    assign frame_out_valid = !fifo_empty;
    assign pop             = frame_out_valid && frame_out_ready;
    assign push_ok         = push && (!fifo_full || pop);
    assign drop            = push && fifo_full && !pop;

    frame_fifo #(
        .WIDTH (DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_frame_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_frame),
        .pop       (pop),
        .pop_data  (frame_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- learning and drop accounting ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            learn_valid <= 1'b0;
            learn_src   <= '0;
            drop_count  <= '0;
        end else begin
            learn_valid <= push_ok && !push_bcast;
            if (push_ok && !push_bcast) learn_src <= push_src;
            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_l2_ingress_port.sv
module tb_l2_ingress_port;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_bit;
    logic [15:0] frame_out;
    logic        frame_out_valid;
    logic        frame_out_ready;
    logic        learn_valid;
    logic [3:0]  learn_src;
    logic [7:0]  drop_count;

    l2_ingress_port #(
        .DEPTH      (16),
        .ADDR_WIDTH (4),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_bit          (rx_bit),
        .frame_out       (frame_out),
        .frame_out_valid (frame_out_valid),
        .frame_out_ready (frame_out_ready),
        .learn_valid     (learn_valid),
        .learn_src       (learn_src),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int npop   = 0;

    // Reference model: buffered frames, pending learn reports, drop total
    logic [15:0] mq[$];
    logic [3:0]  lq[$];
    int          drop_m = 0;

    // Stimulus annotations seen by the model on the next rising edge
    logic        last_bit = 1'b0;
    logic [15:0] cur_frame = '0;
    bit          rand_ready = 0;
    bit          ready_on_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a completed frame lands in the buffer unless it is already full;
    // a pop on the same edge has already been removed by the monitor.
    always @(posedge clk) begin
        if (rst_n && last_bit) begin
            if (mq.size() == FD) begin
                if (drop_m < 255) drop_m++;
            end else begin
                mq.push_back(cur_frame);
                if (cur_frame[7:4] != 4'hF) lq.push_back(cur_frame[7:4]);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", {31'd0, frame_out_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("frame_out", {16'd0, frame_out}, {16'd0, mq[0]});
                if (frame_out_ready) begin
                    void'(mq.pop_front());
                    npop++;
                end
            end
            chk("drop_count", {24'd0, drop_count}, drop_m);
            if (learn_valid) begin
                if (lq.size() == 0) begin
                    chk("learn_unexpected", {31'd0, learn_valid}, 32'd0);
                end else begin
                    chk("learn_src", {28'd0, learn_src}, {28'd0, lq.pop_front()});
                end
            end else if (lq.size() != 0) begin
                chk("learn_missing", 32'd0, 32'd1);
                lq.delete();
            end
        end
    end

    task automatic tick(input logic b, input logic last, input logic [15:0] f);
        @(posedge clk);
        #1;
        rx_bit    = b;
        last_bit  = last;
        cur_frame = f;
        if (rand_ready) frame_out_ready = ($urandom_range(0, 1) == 1);
        if (last && ready_on_last) frame_out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 16'h0);
    endtask

    task automatic send_frame(input logic [15:0] f, input int gap);
        idle(gap);
        for (int i = 15; i >= 0; i--) tick(f[i], (i == 0), f);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_bit   = 1'b1;
        last_bit = 1'b0;
        mq.delete();
        lq.delete();
        drop_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_frame_out", {16'd0, frame_out}, 32'd0);
        chk("rst_valid", {31'd0, frame_out_valid}, 32'd0);
        chk("rst_learn_valid", {31'd0, learn_valid}, 32'd0);
        chk("rst_learn_src", {28'd0, learn_src}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && mq.size() != 0; c++) tick(1'b1, 1'b0, 16'h0);
        chk("drain_timeout", mq.size(), 32'd0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [11:0] r;
        rst_n = 1'b0;
        rx_bit = 1'b1;
        frame_out_ready = 1'b0;

        do_reset();

        // Idle line: nothing buffered, learned or dropped
        idle(50);
        chk("idle_npop", npop, 32'd0);

        // Single frame, then broadcast dest and broadcast src
        frame_out_ready = 1'b1;
        base = npop;
        send_frame(16'h512A, 2);
        idle(4);
        chk("single_npop", npop - base, 32'd1);
        send_frame(16'h5F2C, 3);
        send_frame(16'h51FA, 0);
        drain();
        chk("bcast_npop", npop - base, 32'd3);

        // Overflow: six back-to-back frames into a four-entry buffer
        do_reset();
        frame_out_ready = 1'b0;
        base = npop;
        for (int n = 0; n < 6; n++) send_frame(16'h5120 + 16'(n), 0);
        idle(3);
        chk("ovf_drop", {24'd0, drop_count}, 32'd2);
        frame_out_ready = 1'b1;
        drain();
        chk("ovf_npop", npop - base, 32'd4);

        // Full buffer with a pop on the write edge: nothing lost
        do_reset();
        frame_out_ready = 1'b0;
        base = npop;
        for (int n = 0; n < 4; n++) send_frame(16'h5130 + 16'(n), 0);
        ready_on_last = 1;
        send_frame(16'h5134, 1);
        ready_on_last = 0;
        drain();
        chk("full_pop_drop", {24'd0, drop_count}, 32'd0);
        chk("full_pop_npop", npop - base, 32'd5);

        // Reset during capture discards the partial frame
        do_reset();
        frame_out_ready = 1'b1;
        begin
            logic [15:0] part;
            part = 16'h5133;
            for (int i = 15; i >= 8; i--) tick(part[i], 1'b0, part);
        end
        do_reset();
        frame_out_ready = 1'b1;
        base = npop;
        send_frame(16'h5134, 0);
        drain();
        chk("rst_mid_npop", npop - base, 32'd1);
        chk("rst_mid_drop", {24'd0, drop_count}, 32'd0);

        // Random frames, gaps and backpressure
        do_reset();
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            r = 12'($urandom_range(0, 4095));
            send_frame({4'h5, r}, $urandom_range(0, 3));
        end
        rand_ready = 0;
        frame_out_ready = 1'b1;
        drain();
        chk("learn_leftover", lq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
